// File: rtl/ad9363_rx_delay_cal.sv
// IDELAY tap calibration for the AD9363 LVDS receive path: sweeps all 32 taps against a
// fixed test pattern, then loads the centre of the widest passing window.
module ad9363_rx_delay_cal #(
    parameter int LD_HOLD       = 4,
    parameter int SETTLE_CYCLES = 16,
    parameter int CHECK_CYCLES  = 256,
    parameter int MIN_WINDOW    = 4
) (
    input  logic        rx_clk_bufg,
    input  logic        rst,
    input  logic        cal_start,
    input  logic [11:0] pattern_i,
    input  logic [11:0] pattern_q,
    input  logic        adc_valid,
    input  logic [11:0] adc_data_i1,
    input  logic [11:0] adc_data_q1,
    output logic [4:0]  delay_value,
    output logic        delay_load_en,
    output logic        cal_busy,
    output logic        cal_done,
    output logic        cal_fail,
    output logic [31:0] pass_map,
    output logic [4:0]  win_start,
    output logic [5:0]  win_len
);

    localparam int CW = 16;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_CHECK, S_NEXT, S_SELECT, S_APPLY, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]  tap_q, tap_d;
    logic [4:0]  restore_q, restore_d;
    logic        flag_q, flag_d;
    logic [4:0]  run_start_q, run_start_d;
    logic [5:0]  run_len_q, run_len_d;
    logic [4:0]  best_start_q, best_start_d;
    logic [5:0]  best_len_q, best_len_d;
    logic [4:0]  delay_value_q, delay_value_d;
    logic        load_en_q, load_en_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        fail_q, fail_d;
    logic [31:0] pass_map_q, pass_map_d;
    logic [4:0]  win_start_q, win_start_d;
    logic [5:0]  win_len_q, win_len_d;

    logic        sample_err_s;
    logic        flag_now_s;
    logic        scan_bit_s;
    logic [5:0]  run_len_next_s;
    logic [4:0]  run_start_next_s;

    // Centre of a window; the 6-bit sum never exceeds 31 for a window that fits in 32 taps.
    function automatic logic [4:0] centre_tap(input logic [4:0] start, input logic [5:0] len);
        centre_tap = 5'({1'b0, start} + ((len - 6'd1) >> 1));
    endfunction

    // State and datapath registers.
    always_ff @(posedge rx_clk_bufg) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            tap_q         <= 5'd0;
            restore_q     <= 5'd0;
            flag_q        <= 1'b0;
            run_start_q   <= 5'd0;
            run_len_q     <= 6'd0;
            best_start_q  <= 5'd0;
            best_len_q    <= 6'd0;
            delay_value_q <= 5'd0;
            load_en_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            fail_q        <= 1'b0;
            pass_map_q    <= 32'd0;
            win_start_q   <= 5'd0;
            win_len_q     <= 6'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tap_q         <= tap_d;
            restore_q     <= restore_d;
            flag_q        <= flag_d;
            run_start_q   <= run_start_d;
            run_len_q     <= run_len_d;
            best_start_q  <= best_start_d;
            best_len_q    <= best_len_d;
            delay_value_q <= delay_value_d;
            load_en_q     <= load_en_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            fail_q        <= fail_d;
            pass_map_q    <= pass_map_d;
            win_start_q   <= win_start_d;
            win_len_q     <= win_len_d;
        end
    end

    // Sweep sequencing, per-tap check and window search.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        tap_d         = tap_q;
        restore_d     = restore_q;
        flag_d        = flag_q;
        run_start_d   = run_start_q;
        run_len_d     = run_len_q;
        best_start_d  = best_start_q;
        best_len_d    = best_len_q;
        delay_value_d = delay_value_q;
        load_en_d     = load_en_q;
        busy_d        = busy_q;
        done_d        = done_q;
        fail_d        = fail_q;
        pass_map_d    = pass_map_q;
        win_start_d   = win_start_q;
        win_len_d     = win_len_q;

        sample_err_s     = !adc_valid || (adc_data_i1 != pattern_i) || (adc_data_q1 != pattern_q);
        flag_now_s       = flag_q & ~sample_err_s;
        scan_bit_s       = pass_map_q[cnt_q[4:0]];
        run_len_next_s   = scan_bit_s ? (run_len_q + 6'd1) : 6'd0;
        run_start_next_s = (scan_bit_s && (run_len_q == 6'd0)) ? cnt_q[4:0] : run_start_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (cal_start) begin
                    restore_d     = delay_value_q;
                    done_d        = 1'b0;
                    fail_d        = 1'b0;
                    pass_map_d    = 32'd0;
                    tap_d         = 5'd0;
                    busy_d        = 1'b1;
                    cnt_d         = '0;
                    delay_value_d = 5'd0;
                    load_en_d     = 1'b1;
                    state_d       = S_LOAD;
                end else begin
                    state_d = state_q;
                end
            end
            S_LOAD: begin
                if (cnt_q == CW'(LD_HOLD - 1)) begin
                    cnt_d     = '0;
                    load_en_d = 1'b0;
                    state_d   = S_SETTLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_SETTLE: begin
                if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    flag_d  = 1'b1;
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_CHECK: begin
                if (cnt_q == CW'(CHECK_CYCLES - 1)) begin
                    pass_map_d[tap_q] = flag_now_s;
                    cnt_d             = '0;
                    state_d           = S_NEXT;
                end else begin
                    flag_d = flag_now_s;
                    cnt_d  = cnt_q + 16'd1;
                end
            end
            S_NEXT: begin
                cnt_d = '0;
                if (tap_q == 5'd31) begin
                    run_start_d  = 5'd0;
                    run_len_d    = 6'd0;
                    best_start_d = 5'd0;
                    best_len_d   = 6'd0;
                    state_d      = S_SELECT;
                end else begin
                    tap_d         = tap_q + 5'd1;
                    delay_value_d = tap_q + 5'd1;
                    load_en_d     = 1'b1;
                    state_d       = S_LOAD;
                end
            end
            S_SELECT: begin
                // 32 scan cycles, then one cycle to publish the result and start the final load.
                if (cnt_q == 16'd32) begin
                    win_start_d = best_start_q;
                    win_len_d   = best_len_q;
                    if (best_len_q >= 6'(MIN_WINDOW)) begin
                        delay_value_d = centre_tap(best_start_q, best_len_q);
                        fail_d        = 1'b0;
                    end else begin
                        delay_value_d = restore_q;
                        fail_d        = 1'b1;
                    end
                    load_en_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_APPLY;
                end else begin
                    run_len_d   = run_len_next_s;
                    run_start_d = run_start_next_s;
                    if (run_len_next_s > best_len_q) begin
                        best_len_d   = run_len_next_s;
                        best_start_d = run_start_next_s;
                    end else begin
                        best_len_d = best_len_q;
                    end
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_APPLY: begin
                if (cnt_q == CW'(LD_HOLD - 1)) begin
                    cnt_d     = '0;
                    load_en_d = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign delay_value   = delay_value_q;
    assign delay_load_en = load_en_q;
    assign cal_busy      = busy_q;
    assign cal_done      = done_q;
    assign cal_fail      = fail_q;
    assign pass_map      = pass_map_q;
    assign win_start     = win_start_q;
    assign win_len       = win_len_q;

endmodule

// File: tb/tb_ad9363_rx_delay_cal.sv
// Scoreboard bench for ad9363_rx_delay_cal: a tap-dependent data-eye model drives the ADC
// inputs, expectations are queued at cal_start and checked when cal_done rises.
module tb_ad9363_rx_delay_cal;

    localparam int LD_HOLD = 4;
    localparam int LATENCY = 8902;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cal_start = 1'b0;
    logic [11:0] pattern_i = 12'd0;
    logic [11:0] pattern_q = 12'd0;
    logic        adc_valid = 1'b0;
    logic [11:0] adc_data_i1 = 12'd0;
    logic [11:0] adc_data_q1 = 12'd0;
    logic [4:0]  delay_value;
    logic        delay_load_en;
    logic        cal_busy;
    logic        cal_done;
    logic        cal_fail;
    logic [31:0] pass_map;
    logic [4:0]  win_start;
    logic [5:0]  win_len;

    ad9363_rx_delay_cal dut (
        .rx_clk_bufg  (clk),
        .rst          (rst),
        .cal_start    (cal_start),
        .pattern_i    (pattern_i),
        .pattern_q    (pattern_q),
        .adc_valid    (adc_valid),
        .adc_data_i1  (adc_data_i1),
        .adc_data_q1  (adc_data_q1),
        .delay_value  (delay_value),
        .delay_load_en(delay_load_en),
        .cal_busy     (cal_busy),
        .cal_done     (cal_done),
        .cal_fail     (cal_fail),
        .pass_map     (pass_map),
        .win_start    (win_start),
        .win_len      (win_len)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pm;
        logic [4:0]  ws;
        logic [5:0]  wl;
        logic [4:0]  dv;
        logic        fail;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          t0 = 0;
    logic [31:0] cur_good = 32'd0;
    logic        inject_q0 = 1'b0;
    int          corrupt_mode = 0;
    logic [4:0]  model_dv = 5'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Reference: longest run of passing taps, earliest on ties, centre or restore.
    function automatic exp_t model(input logic [31:0] pm, input logic [4:0] restore);
        exp_t e;
        int best_s = 0;
        int best_l = 0;
        for (int s = 0; s < 32; s++) begin
            int l = 0;
            while (s + l < 32 && pm[s + l]) l++;
            if (l > best_l) begin
                best_l = l;
                best_s = s;
            end
        end
        e.pm   = pm;
        e.ws   = 5'(best_s);
        e.wl   = 6'(best_l);
        e.fail = (best_l < 4);
        e.dv   = e.fail ? restore : 5'(best_s + (best_l - 1) / 2);
        return e;
    endfunction

    function automatic logic [31:0] range_mask(input int lo, input int hi);
        logic [31:0] m = 32'd0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Data-eye model: bad taps corrupt every 16th cycle in a randomly chosen way.
    initial begin
        forever begin
            @(negedge clk);
            adc_valid   = 1'b1;
            adc_data_i1 = pattern_i;
            adc_data_q1 = pattern_q;
            if (!cur_good[delay_value] && (cyc % 16 == 0)) begin
                case (corrupt_mode)
                    0: adc_valid = 1'b0;
                    1: adc_data_i1 = pattern_i ^ (12'd1 << $urandom_range(11, 0));
                    default: adc_data_q1 = pattern_q ^ (12'd1 << $urandom_range(11, 0));
                endcase
            end
            if (inject_q0 && (cyc - t0 == 276)) adc_data_q1 = pattern_q ^ 12'h800;
        end
    end

    // Monitor: load/value protocol and scoreboard comparison on cal_done rising.
    initial begin
        logic prev_done = 1'b0;
        logic prev_le = 1'b0;
        logic [4:0] prev_dv = 5'd0;
        int load_cnt = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                load_cnt = 0;
            end else begin
                if (delay_load_en) load_cnt++;
                if (delay_value != prev_dv) chk("dv_change_on_load_start", {31'd0, delay_load_en && !prev_le}, 32'd1);
                if (cal_done && !prev_done) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pass_map", pass_map, e.pm);
                        chk("win_start", {27'd0, win_start}, {27'd0, e.ws});
                        chk("win_len", {26'd0, win_len}, {26'd0, e.wl});
                        chk("delay_value", {27'd0, delay_value}, {27'd0, e.dv});
                        chk("cal_fail", {31'd0, cal_fail}, {31'd0, e.fail});
                        chk("busy_at_done", {31'd0, cal_busy}, 32'd0);
                        chk("latency", cyc - t0, LATENCY);
                        chk("load_cycles", load_cnt, 33 * LD_HOLD);
                    end
                    load_cnt = 0;
                end
            end
            prev_done = cal_done;
            prev_le   = delay_load_en;
            prev_dv   = delay_value;
        end
    end

    task automatic check_reset_state(input string tag);
        chk({tag, "_delay_value"}, {27'd0, delay_value}, 32'd0);
        chk({tag, "_load_en"}, {31'd0, delay_load_en}, 32'd0);
        chk({tag, "_busy"}, {31'd0, cal_busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, cal_done}, 32'd0);
        chk({tag, "_fail"}, {31'd0, cal_fail}, 32'd0);
        chk({tag, "_pass_map"}, pass_map, 32'd0);
        chk({tag, "_win_start"}, {27'd0, win_start}, 32'd0);
        chk({tag, "_win_len"}, {26'd0, win_len}, 32'd0);
    endtask

    task automatic start_cal(input logic [31:0] good, input logic inj, input logic expect_result);
        exp_t e;
        logic [31:0] pm;
        @(negedge clk);
        pattern_i    = 12'($urandom);
        pattern_q    = 12'($urandom);
        corrupt_mode = int'($urandom_range(2, 0));
        cur_good     = good;
        inject_q0    = inj;
        pm           = inj ? (good & ~32'd1) : good;
        if (expect_result) begin
            e = model(pm, model_dv);
            model_dv = e.dv;
            exp_q.push_back(e);
        end
        cal_start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        cal_start = 1'b0;
        chk("busy_cycle1", {31'd0, cal_busy}, 32'd1);
        chk("load_en_cycle1", {31'd0, delay_load_en}, 32'd1);
    endtask

    task automatic wait_done(input int pulse_at);
        logic got = 1'b0;
        for (int k = 0; k < 10000; k++) begin
            @(negedge clk);
            cal_start = (pulse_at > 0) && (cyc - t0 == pulse_at);
            if (cal_done) begin
                got = 1'b1;
                break;
            end
        end
        cal_start = 1'b0;
        if (!got) begin
            chk("done_timeout", 32'd0, 32'd1);
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic run_cal(input logic [31:0] good, input logic inj, input int pulse_at);
        start_cal(good, inj, 1'b1);
        wait_done(pulse_at);
    endtask

    initial begin
        repeat (5) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);

        run_cal(32'hFFFF_FFFF, 1'b0, 0);
        run_cal(range_mask(8, 19), 1'b0, int'($urandom_range(8000, 300)));
        run_cal(range_mask(3, 6) | range_mask(20, 27), 1'b0, 0);
        run_cal(range_mask(2, 5) | range_mask(10, 13), 1'b0, 0);
        run_cal(32'hFFFF_FFFF, 1'b1, 0);

        // Abort the sweep while tap 10 is in CHECK.
        start_cal(32'hFFFF_FFFF, 1'b0, 1'b0);
        while (cyc - t0 < 2900) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("abort");
        @(posedge clk);
        #1 rst = 1'b0;
        model_dv = 5'd0;
        repeat (10) @(negedge clk);
        chk("idle_after_abort_busy", {31'd0, cal_busy}, 32'd0);
        chk("idle_after_abort_load_en", {31'd0, delay_load_en}, 32'd0);

        run_cal(range_mask(7, 11), 1'b0, 0);
        run_cal(range_mask(5, 7), 1'b0, 0);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ad9363_rx_delay_cal.md
# ad9363_rx_delay_cal

Calibrates the IDELAYE2 tap setting that the AD9363 LVDS receive path applies to its frame and data lanes. The block sweeps all 32 taps while the AD9363 outputs a fixed test pattern, and records pass/fail per tap. It then finds the widest contiguous passing window and loads the centre tap. It sits between the RX interface's `delay_value`/`delay_load_en` inputs and its `adc_valid`/`adc_data_*` outputs, running in the received-clock domain.

## Interface
Parameters:
- LD_HOLD, 4: cycles `delay_load_en` is held high per load (≥ 2, so the IDELAY clock domain samples it).
- SETTLE_CYCLES, 16: wait after load release before checking. Covers IDELAY, IDDR and output-register latency.
- CHECK_CYCLES, 256: cycles evaluated per tap.
- MIN_WINDOW, 4: minimum passing-window width for success.

Ports:
- rx_clk_bufg  in  1  clock; reset rst, synchronous, active-high; clock rx_clk_bufg.
- rst  in  1  synchronous active-high reset.
- cal_start  in  1  single-cycle start request.
- pattern_i  in  12  expected I sample (AD9363 fixed test pattern).
- pattern_q  in  12  expected Q sample.
- adc_valid  in  1  sample valid from the RX interface.
- adc_data_i1  in  12  I sample.
- adc_data_q1  in  12  Q sample.
- delay_value  out  5  tap value to the IDELAYs.
- delay_load_en  out  1  IDELAY load enable.
- cal_busy  out  1  calibration in progress.
- cal_done  out  1  calibration finished; sticky.
- cal_fail  out  1  no window ≥ MIN_WINDOW; valid when cal_done=1.
- pass_map  out  32  bit n = tap n passed.
- win_start  out  5  start tap of the best window.
- win_len  out  6  width of the best window (0..32).

## Operation
- Reset values:
  - delay_value=0, delay_load_en=0, cal_busy=0, cal_done=0, cal_fail=0.
  - pass_map=0, win_start=0, win_len=0.
  - FSM in IDLE.
- FSM states: IDLE, LOAD, SETTLE, CHECK, NEXT, SELECT, APPLY, DONE.
- IDLE/DONE:
  - On cal_start, save the current delay_value as restore_tap.
  - Clear cal_done, cal_fail, pass_map and tap counter to 0; set cal_busy=1; go to LOAD.
- cal_start in any other state is ignored.
- LOAD:
  - delay_value = tap and delay_load_en=1 for LD_HOLD cycles, then go to SETTLE.
  - delay_value stays stable from the first LOAD cycle to the end of CHECK.
- SETTLE: count SETTLE_CYCLES cycles, ignoring inputs, then go to CHECK.
- CHECK:
  - Count CHECK_CYCLES cycles.
  - A cycle is an error if adc_valid=0, or adc_data_i1≠pattern_i, or adc_data_q1≠pattern_q.
  - Any error clears the tap's pass flag (flag starts at 1).
  - At the end, write the flag to pass_map[tap].
- NEXT: if tap==31, go to SELECT; else increment tap and go to LOAD.
- SELECT:
  - Scan pass_map bits 0..31, one bit per cycle.
  - Track the current run start and length, and the best run.
  - The best run is replaced only on a strictly longer run, so the earliest run wins ties.
  - There is no wrap-around; tap 31 and tap 0 are not adjacent.
- Results:
  - If best_len ≥ MIN_WINDOW: target = best_start + ((best_len−1)>>1), cal_fail=0.
  - Otherwise: target = restore_tap, cal_fail=1.
  - win_start/win_len report the best run in both cases; 0/0 if no tap passed.
- APPLY: load target using the LOAD timing (LD_HOLD cycles), then go to DONE.
- DONE: cal_busy=0, cal_done=1. Outputs are held until the next cal_start or rst.
- rst in any state: immediate return to reset values, with the sweep abandoned.

## Timing
- cal_start sampled at cycle 0: cal_busy=1 and delay_load_en=1 from cycle 1.
- Per tap: LD_HOLD + SETTLE_CYCLES + CHECK_CYCLES + 1 cycles. With defaults that is 277 cycles; ×32 = 8864 cycles.
- SELECT takes 33 cycles: 32 scan plus 1 compute. APPLY takes LD_HOLD cycles.
- Total from cal_start to cal_done=1 with defaults: 8864 + 33 + 4 + 1 = 8902 cycles.
- pass_map bit n is updated in the last CHECK cycle of tap n. win_start/win_len are updated on SELECT exit.
- delay_load_en is never high outside LOAD/APPLY. delay_value changes only in the first LOAD/APPLY cycle.
- Widths:
  - tap counter: 5 bits.
  - run length: 6 bits (reaches 32).
  - target arithmetic: 6 bits, truncated to 5; the result is always ≤ 31.

## Test plan
- Bench model: a tap is good iff it is in a configured set; on a bad tap it corrupts data every 16th cycle.
- All 32 taps good → pass_map=0xFFFFFFFF, win_start=0, win_len=32, delay_value=15, cal_fail=0, cal_done at cycle 8902.
- Taps 8..19 good → pass_map=0x000FFF00, win_len=12, final delay_value=13 (one final 4-cycle load pulse after SELECT).
- Taps 3..6 and 20..27 good → win_start=20, win_len=8, delay_value=23. Also run equal windows 2..5 and 10..13 → win_start=2, delay_value=3.
- Taps 5..7 good (width 3) with delay_value=9 before start → cal_fail=1, win_len=3, delay_value restored to 9.
- Single mismatch on pattern_q in the last CHECK cycle of tap 0 (all else good) → pass_map bit0=0, win_start=1, win_len=31, delay_value=16.
- cal_start pulsed mid-sweep → ignored, total latency unchanged. rst asserted during CHECK of tap 10 → next cycle all outputs at reset values, FSM IDLE. A new cal_start then runs a full sweep.
